// File: rtl/uart_pkg.sv
// uart_pkg
// Shared definitions for the UART transmit path: frame state encoding,
// parity selection codes, data-length constants, the captured frame
// configuration record and small helpers used by the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    localparam int DATA_BITS_7 = 7;
    localparam int DATA_BITS_8 = 8;

    // Everything needed to send one frame, captured together on a request
    typedef struct packed {
        logic [7:0] data;
        logic       d_num;
        logic [1:0] par;
        logic       s_num;
    } frame_cfg_t;

    // Code 2'b11 is deliberately treated the same as PAR_NONE
    function automatic logic parity_enabled(input logic [1:0] par);
        return (par == PAR_ODD) || (par == PAR_EVEN);
    endfunction

    // Parity covers only the bits actually sent, so bit 7 is masked in 7-bit mode
    function automatic logic parity_bit(input frame_cfg_t cfg);
        logic [7:0] bits;
        logic       ones_odd;
        bits     = cfg.d_num ? cfg.data : {1'b0, cfg.data[6:0]};
        ones_odd = ^bits;
        return (cfg.par == PAR_ODD) ? ~ones_odd : ones_odd;
    endfunction

    function automatic logic [2:0] last_bit_index(input logic d_num);
        return d_num ? 3'(DATA_BITS_8 - 1) : 3'(DATA_BITS_7 - 1);
    endfunction

endpackage

// File: rtl/uart_edge_det.sv
// uart_edge_det
// Single-bit rising-edge detector. The delayed copy is registered and the
// edge output is combinational, so it is high for the one cycle in which
// the input is already high but its registered copy is still low.
//
// Ports:
//   clkdiv  in  system clock
//   reset   in  synchronous active-high reset (clears the delayed copy)
//   sig     in  level signal to watch
//   rise    out high for one cycle on a 0->1 transition of sig
module uart_edge_det (
    input  logic clkdiv,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    always_ff @(posedge clkdiv) begin
        if (reset) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Serial transmit stage. Each rising edge of enable_tx requests one
// asynchronous frame: start bit, 7 or 8 data bits LSB first, optional
// parity bit and 1 or 2 stop bits, each bit lasting one baud tick.
// The frame format is captured with the data at request time.
//
// Optional feature: define UART_TX_HOLD_EN to add a one-entry holding
// register so a request arriving mid-frame is queued rather than dropped.
//
// Ports:
//   clkdiv      in  system clock
//   reset       in  synchronous active-high reset
//   bd_rate_tx  in  baud strobe (level, only its rising edge is used)
//   enable_tx   in  transmit request (level, a 0->1 transition is one request)
//   data_in_tx  in  byte to send
//   d_num       in  0 = 7 data bits, 1 = 8 data bits
//   par         in  00 none, 01 odd, 10 even, 11 none
//   s_num       in  0 = one stop bit, 1 = two stop bits
//   tx          out serial line, idle high
//   busy        out frame armed or in progress
//   done        out one-cycle pulse at the end of the last stop bit
//   overrun     out one-cycle pulse when a request is dropped
module uart_tx_frame
    import uart_pkg::*;
(
    input  logic       clkdiv,
    input  logic       reset,
    input  logic       bd_rate_tx,
    input  logic       enable_tx,
    input  logic [7:0] data_in_tx,
    input  logic       d_num,
    input  logic [1:0] par,
    input  logic       s_num,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       overrun
);

    logic       tick;
    logic       req;
    tx_state_t  state;
    frame_cfg_t frame;
    frame_cfg_t in_cfg;
    logic [2:0] bit_idx;
    logic       stop_cnt;

`ifdef UART_TX_HOLD_EN
    frame_cfg_t hold_cfg;
    logic       hold_full;
`endif

    uart_edge_det u_tick_det (
        .clkdiv (clkdiv),
        .reset  (reset),
        .sig    (bd_rate_tx),
        .rise   (tick)
    );

    uart_edge_det u_req_det (
        .clkdiv (clkdiv),
        .reset  (reset),
        .sig    (enable_tx),
        .rise   (req)
    );

    assign in_cfg = {data_in_tx, d_num, par, s_num};

    // Frame sequencer. tx/busy/done/overrun are all registered here so the
    // line changes exactly one clock after a detected tick. A tick coinciding
    // with a request in IDLE is not used: ARMED always waits for a fresh tick.
    always_ff @(posedge clkdiv) begin
        if (reset) begin
            state    <= IDLE;
            frame    <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overrun  <= 1'b0;
`ifdef UART_TX_HOLD_EN
            hold_cfg  <= '0;
            hold_full <= 1'b0;
`endif
        end else begin
            done    <= 1'b0;
            overrun <= 1'b0;

            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (req) begin
                        frame <= in_cfg;
                        busy  <= 1'b1;
                        state <= ARMED;
                    end
                end

                ARMED: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end

                START: begin
                    if (tick) begin
                        bit_idx <= 3'd0;
                        tx      <= frame.data[0];
                        state   <= DATA;
                    end
                end

                DATA: begin
                    if (tick) begin
                        if (bit_idx == last_bit_index(frame.d_num)) begin
                            if (parity_enabled(frame.par)) begin
                                tx    <= parity_bit(frame);
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= frame.data[bit_idx + 3'd1];
                        end
                    end
                end

                PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end

                STOP: begin
                    if (tick) begin
                        if (stop_cnt == frame.s_num) begin
                            done <= 1'b1;
`ifdef UART_TX_HOLD_EN
                            // A queued frame goes straight to ARMED so busy never drops
                            if (hold_full) begin
                                frame     <= hold_cfg;
                                hold_full <= 1'b0;
                                state     <= ARMED;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
`else
                            busy  <= 1'b0;
                            state <= IDLE;
`endif
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end

                default: begin
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // Requests arriving while a frame is armed or running
            if (req && (state != IDLE)) begin
`ifdef UART_TX_HOLD_EN
                if (!hold_full) begin
                    hold_cfg  <= in_cfg;
                    hold_full <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
`else
                overrun <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame
// Directed bench for uart_tx_frame. A free-running baud strobe (two clocks
// high out of sixteen) drives the DUT; each frame's expected line sequence
// is written out by hand as a string of bits in transmission order and the
// line is sampled in the middle of every bit period.
module tb_uart_tx_frame;

    logic       clkdiv;
    logic       reset;
    logic       bd_rate_tx;
    logic       enable_tx;
    logic [7:0] data_in_tx;
    logic       d_num;
    logic [1:0] par;
    logic       s_num;
    logic       tx;
    logic       busy;
    logic       done;
    logic       overrun;

    int   tests_run;
    int   tests_failed;
    int   bd_cnt;
    event baud_rise;

    uart_tx_frame dut (
        .clkdiv     (clkdiv),
        .reset      (reset),
        .bd_rate_tx (bd_rate_tx),
        .enable_tx  (enable_tx),
        .data_in_tx (data_in_tx),
        .d_num      (d_num),
        .par        (par),
        .s_num      (s_num),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun)
    );

    initial clkdiv = 1'b0;
    always #5 clkdiv = ~clkdiv;

    // Baud strobe: rises every 16 clocks and stays high for 2 clocks
    initial begin
        bd_cnt     = 15;
        bd_rate_tx = 1'b0;
        forever begin
            @(negedge clkdiv);
            bd_cnt     = (bd_cnt == 15) ? 0 : bd_cnt + 1;
            bd_rate_tx = (bd_cnt < 2);
            if (bd_cnt == 0) -> baud_rise;
        end
    end

    task automatic checkOutput(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Raises a request in the middle of a baud period while the DUT is idle
    task automatic applyStimulus(input logic [7:0] data, input logic dn,
                                 input logic [1:0] pr, input logic sn);
        @(baud_rise);
        repeat (8) @(negedge clkdiv);
        data_in_tx = data;
        d_num      = dn;
        par        = pr;
        s_num      = sn;
        enable_tx  = 1'b1;
        @(posedge clkdiv);
        #1;
        checkOutput("busy_rise", busy, 1);
        checkOutput("tx_armed", tx, 1);
        @(negedge clkdiv);
        enable_tx = 1'b0;
    endtask

    // A further request during a frame; with the hold built in, the first is
    // queued (data 0x3C, 8 bits, no parity, 1 stop) and a third one overruns
    task automatic extraRequests();
        data_in_tx = 8'h3C;
        d_num      = 1'b1;
        par        = 2'b00;
        s_num      = 1'b0;
        @(negedge clkdiv);
        enable_tx = 1'b1;
        @(posedge clkdiv);
        #1;
`ifdef UART_TX_HOLD_EN
        checkOutput("hold_no_overrun", overrun, 0);
        @(negedge clkdiv);
        enable_tx = 1'b0;
        @(negedge clkdiv);
        data_in_tx = 8'h99;
        enable_tx  = 1'b1;
        @(posedge clkdiv);
        #1;
        checkOutput("hold_full_overrun", overrun, 1);
`else
        checkOutput("overrun_pulse", overrun, 1);
`endif
        @(posedge clkdiv);
        #1;
        checkOutput("overrun_one_cycle", overrun, 0);
        @(negedge clkdiv);
        enable_tx = 1'b0;
    endtask

    // Samples the first nsample bit periods against the expected string;
    // inject 1 clears data_in_tx mid-frame, inject 2 issues extra requests
    task automatic sampleBits(input string exp, input int nsample, input int inject);
        for (int i = 0; i < nsample; i++) begin
            @(baud_rise);
            repeat (4) @(posedge clkdiv);
            #1;
            checkOutput($sformatf("tx_bit%0d", i), tx, (exp[i] == "1") ? 8'd1 : 8'd0);
            if (i == 0) checkOutput("busy_in_frame", busy, 1);
            if (i == 2 && inject == 1) data_in_tx = 8'h00;
            if (i == 2 && inject == 2) extraRequests();
        end
    endtask

    // The tick that ends the last stop bit pulses done for exactly one clock
    task automatic checkDone(input logic exp_busy);
        @(baud_rise);
        @(posedge clkdiv);
        #1;
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after_done", busy, exp_busy);
        checkOutput("tx_after_done", tx, 1);
        @(posedge clkdiv);
        #1;
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        enable_tx    = 1'b0;
        data_in_tx   = 8'h00;
        d_num        = 1'b1;
        par          = 2'b00;
        s_num        = 1'b0;
        repeat (3) @(posedge clkdiv);
        #1;
        checkOutput("reset_tx", tx, 1);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_overrun", overrun, 0);
        @(negedge clkdiv);
        reset = 1'b0;

        $display("[TB] frame 0x55, 8N1");
        applyStimulus(8'h55, 1'b1, 2'b00, 1'b0);
        sampleBits("0101010101", 10, 0);
        checkDone(1'b0);

        $display("[TB] frame 0xA3, 8E2");
        applyStimulus(8'hA3, 1'b1, 2'b10, 1'b1);
        sampleBits("011000101011", 12, 0);
        checkDone(1'b0);

        $display("[TB] frame 0x41, 7O1");
        applyStimulus(8'h41, 1'b0, 2'b01, 1'b0);
        sampleBits("0100000111", 10, 0);
        checkDone(1'b0);

        $display("[TB] frame 0xFF, par=11, data cleared mid-frame");
        applyStimulus(8'hFF, 1'b1, 2'b11, 1'b0);
        sampleBits("0111111111", 10, 1);
        checkDone(1'b0);

        $display("[TB] reset during data bit 3");
        applyStimulus(8'h55, 1'b1, 2'b00, 1'b0);
        sampleBits("01010", 5, 0);
        @(negedge clkdiv);
        reset = 1'b1;
        @(posedge clkdiv);
        #1;
        checkOutput("midreset_tx", tx, 1);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_done", done, 0);
        @(negedge clkdiv);
        reset = 1'b0;
        repeat (30) @(posedge clkdiv);
        #1;
        checkOutput("midreset_no_done", done, 0);
        checkOutput("midreset_idle_tx", tx, 1);
        applyStimulus(8'h55, 1'b1, 2'b00, 1'b0);
        sampleBits("0101010101", 10, 0);
        checkDone(1'b0);

        $display("[TB] request while busy");
        applyStimulus(8'hC5, 1'b1, 2'b00, 1'b0);
        sampleBits("0101000111", 10, 2);
`ifdef UART_TX_HOLD_EN
        checkDone(1'b1);
        sampleBits("0001111001", 10, 0);
        checkDone(1'b0);
`else
        checkDone(1'b0);
`endif

        repeat (4) @(posedge clkdiv);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Serial transmit stage fed by the UART controller. Takes the controller's baud strobe, transmit enable, data byte, data-length, parity and stop-bit selections, and serialises one asynchronous frame per request onto the `tx` line: start bit, 7 or 8 data bits LSB first, optional parity, then 1 or 2 stop bits. Reports frame progress to the controller through busy/done.

## Interface
- No parameters. Frame format is fully runtime-selected.
- `clkdiv` in 1: system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high.
- `bd_rate_tx` in 1: baud tick from the controller, level-type and possibly several clocks wide. Only its rising edge is used.
- `enable_tx` in 1: transmit request, level-type. A 0→1 transition is one request.
- `data_in_tx` in 8: byte to send.
- `d_num` in 1: 0 = 7 data bits (bits 6:0), 1 = 8 data bits.
- `par` in 2: 00 none, 01 odd, 10 even, 11 treated as none.
- `s_num` in 1: 0 = one stop bit, 1 = two stop bits.
- `tx` out 1: serial line, idle high.
- `busy` out 1: frame armed or in progress.
- `done` out 1: one-cycle pulse at end of the last stop bit.
- `overrun` out 1: one-cycle pulse when a request is dropped.

## Operation
- Edge detect:
  - `tick` = `bd_rate_tx` & ~`bd_rate_tx_q`.
  - `req` = `enable_tx` & ~`enable_tx_q`.
  - Both `_q` registers reset to 0.
- Capture:
  - On `req` in IDLE, latch `data_in_tx`, `d_num`, `par` and `s_num` into frame registers, then go to ARMED.
  - Inputs that change later do not affect the frame in flight.
- State machine and per-state `tx` value:
  - IDLE: `tx`=1.
  - ARMED: `tx`=1.
  - START: `tx`=0.
  - DATA: `tx`=current data bit.
  - PARITY: `tx`=parity bit.
  - STOP: `tx`=1.
- Transitions, each taken on `tick`:
  - ARMED→START.
  - START→DATA, bit index 0.
  - DATA: bit index increments. At the last index (6 or 7), go to PARITY if parity is enabled, else STOP.
  - PARITY→STOP.
  - STOP: remain for 1 or 2 ticks per `s_num`. On the final tick go to IDLE and pulse `done`.
- Parity is computed over the transmitted data bits only.
  - Odd: the total count of ones (data plus parity) is odd.
  - Even: the total count is even.
- `busy` = 1 in every state except IDLE.
- A `req` while busy is ignored and pulses `overrun`, unless holding is compiled in (see Configuration).
- `tick` and `req` in the same cycle in IDLE: capture happens, and that tick is not consumed. START waits for the next tick.

## Timing
- Reset values:
  - `tx`=1; `busy`, `done`, `overrun` = 0.
  - State IDLE; bit and stop counters 0; edge registers 0; hold empty.
- Reset mid-frame returns to IDLE within one clock and drops the frame without a `done` pulse.
- Output registers:
  - `tx` is registered and changes one clock after the tick edge is detected.
  - `busy` rises one clock after `req`.
- Latency from `req` to start bit: 1 clock plus up to one baud period (waiting in ARMED for a tick).
- Frame length in ticks = 1 + (7|8) + (0|1) + (1|2), i.e. 9 to 12 bit periods.
- `done` is asserted in the same cycle the state returns to IDLE.
- `done` and `overrun` never last more than one clock.

## Configuration
- `UART_TX_HOLD_EN` defined: adds a one-entry holding register.
  - A `req` while busy stores data and config if the hold is empty.
  - On the cycle `done` pulses, a full hold loads directly into ARMED (`busy` stays 1) and the hold empties.
  - A `req` while busy with the hold full is dropped and pulses `overrun`.
- Undefined: no hold. Every `req` while busy is dropped with `overrun`.

## Structure
- Shared package `uart_pkg`:
  - State enum (IDLE, ARMED, START, DATA, PARITY, STOP).
  - Parity codes PAR_NONE=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10.
  - Data-length constants 7/8.
- Sub-module `uart_edge_det`: single-bit rising-edge detector with synchronous reset. Instantiated twice, for `bd_rate_tx` and `enable_tx`.

## Test plan
- Data 0x55, `d_num`=1, `par`=00, `s_num`=0:
  - `tx` per tick is 0,1,0,1,0,1,0,1,0,1.
  - `done` after the 10th bit period.
- Data 0xA3, `d_num`=1, `par`=10, `s_num`=1:
  - Data bits 1,1,0,0,0,1,0,1, then parity 0, then stop 1,1.
  - 12 bit periods.
- Data 0x41, `d_num`=0, `par`=01, `s_num`=0:
  - Data bits 1,0,0,0,0,0,1, then parity 1, then stop 1.
  - Bit 7 of the input is never sent.
- `par`=11 with data 0xFF: no parity bit, 10-period frame. Change `data_in_tx` to 0x00 mid-frame: `tx` is unaffected.
- Reset mid-frame:
  - Assert `reset` during DATA bit 3. Next clock: `tx`=1, `busy`=0, no `done`.
  - Then `req`: a clean new frame.
- Second `req` while busy:
  - Without the macro: `overrun` pulses.
  - With `UART_TX_HOLD_EN`: a second frame follows the first with no idle gap beyond one ARMED tick.
  - With the macro, a third `req` during the first frame: `overrun`.
